// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: blanking pattern,
// active scan phase and the active-low hex glyph table.
package seg_pkg;

    // All segments off (active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Scan phase (counter[1:0]) during which the addressed digit is lit.
    localparam logic [1:0] ACTIVE_PHASE = 2'b01;

    // Active-low {g,f,e,d,c,b,a} glyphs, entry n occupies bits [7n +: 7].
    localparam logic [16*7-1:0] HEX_SEG_TABLE = {
        7'h0E, // F
        7'h06, // E
        7'h21, // d
        7'h46, // C
        7'h03, // b
        7'h08, // A
        7'h10, // 9
        7'h00, // 8
        7'h78, // 7
        7'h02, // 6
        7'h12, // 5
        7'h19, // 4
        7'h30, // 3
        7'h24, // 2
        7'h79, // 1
        7'h40  // 0
    };

endpackage

// File: rtl/seg_scan_driver_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] pattern
);

    logic [6:0] table_index;

    assign table_index = {3'b000, value} * 7'd7;

    // Table lookup; every nibble value has a glyph, so no default is needed.
    always_comb begin
        pattern = HEX_SEG_TABLE[table_index +: 7];
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver. A prescaler paces a
// 4-bit scan counter; display bytes arrive over valid/ready, wait in a
// one-byte pending buffer and are shifted into the shadow digits only at
// the 15->0 frame wrap so a frame is never drawn with mixed contents.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [3:0] counter,
    output logic [3:0] digit,
    output logic [6:0] seg,
    output logic       frame_tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] prescale_reg;
    logic [PW-1:0] prescale_next;
    logic [3:0]    counter_reg;
    logic [3:0]    counter_next;
    logic          frame_tick_reg;
    logic [15:0]   shadow_reg;
    logic [15:0]   shadow_next;
    logic [7:0]    pend_byte_reg;
    logic [7:0]    pend_byte_next;
    logic          pend_valid_reg;
    logic          pend_valid_next;

    logic tick;
    logic wrap;
    logic accept;
    logic commit;

    assign tick   = (prescale_reg == PRESCALE_LAST);
    assign wrap   = tick && (counter_reg == 4'hF);
    assign accept = data_valid && !pend_valid_reg;
    // accept needs an empty buffer and commit a full one, so they never coincide;
    // a byte accepted on a wrap edge therefore waits for the following wrap.
    assign commit = wrap && pend_valid_reg;

    // Next-state for prescaler, scan counter, pending buffer and shadow digits.
    always_comb begin
        prescale_next   = tick ? '0 : prescale_reg + 1'b1;
        counter_next    = tick ? counter_reg + 4'd1 : counter_reg;
        shadow_next     = shadow_reg;
        pend_byte_next  = pend_byte_reg;
        pend_valid_next = pend_valid_reg;
        if (commit) begin
            shadow_next     = {shadow_reg[7:0], pend_byte_reg};
            pend_valid_next = 1'b0;
        end else if (accept) begin
            pend_byte_next  = data_in;
            pend_valid_next = 1'b1;
        end
    end

    // State registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prescale_reg   <= '0;
            counter_reg    <= 4'd0;
            frame_tick_reg <= 1'b0;
            shadow_reg     <= 16'h0000;
            pend_byte_reg  <= 8'h00;
            pend_valid_reg <= 1'b0;
        end else begin
            prescale_reg   <= prescale_next;
            counter_reg    <= counter_next;
            frame_tick_reg <= wrap;
            shadow_reg     <= shadow_next;
            pend_byte_reg  <= pend_byte_next;
            pend_valid_reg <= pend_valid_next;
        end
    end

    // Digit slot gi is the gi-th display from the left, i.e. d3 first.
    logic [3:0] shadow_digit [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign shadow_digit[gi] = shadow_reg[15 - 4*gi -: 4];
        end
    endgenerate

    logic [6:0] hex_pattern;

    hex_to_seg u_hex_to_seg (
        .value   (digit),
        .pattern (hex_pattern)
    );

    // Digit select and blanking outside the active phase to avoid ghosting.
    always_comb begin
        digit = shadow_digit[counter_reg[3:2]];
        seg   = (counter_reg[1:0] == ACTIVE_PHASE) ? hex_pattern : SEG_BLANK;
    end

    assign counter    = counter_reg;
    assign frame_tick = frame_tick_reg;
    assign data_ready = !pend_valid_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with PRESCALE=4 (64-cycle frame).
// The stimulus side updates an edge-counting reference model and queues the
// expected outputs; a negedge monitor pops and compares them.
module tb_seg_scan_driver;

    localparam int PRESCALE = 4;
    localparam int FRAME    = 16 * PRESCALE;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic [3:0] counter;
    logic [3:0] digit;
    logic [6:0] seg;
    logic       frame_tick;

    seg_scan_driver #(.PRESCALE(PRESCALE)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .counter    (counter),
        .digit      (digit),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference glyphs, active-low {g..a}.
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [3:0] cnt;
        logic [3:0] dig;
        logic [6:0] sg;
        logic       rdy;
        logic       ft;
        int         edge_no;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int fails  = 0;

    // Reference model: time is the number of clock edges since reset release.
    int          m_edges = 0;
    logic [15:0] m_shadow = 16'h0000;
    logic        m_pend = 1'b0;
    logic [7:0]  m_byte = 8'h00;

    task automatic model_edge(input logic rst_n, input logic v, input logic [7:0] d);
        exp_t x;
        int   c;
        if (!rst_n) begin
            m_edges  = 0;
            m_shadow = 16'h0000;
            m_pend   = 1'b0;
        end else begin
            m_edges++;
            if ((m_edges % FRAME) == 0 && m_pend) begin
                m_shadow = {m_shadow[7:0], m_byte};
                m_pend   = 1'b0;
            end else if (v && !m_pend) begin
                m_byte = d;
                m_pend = 1'b1;
            end
        end
        c       = (m_edges / PRESCALE) % 16;
        x.cnt   = 4'(c);
        x.dig   = 4'((m_shadow >> (4 * (3 - c / 4))) & 16'hF);
        x.sg    = ((c % 4) == 1) ? seg_tab[x.dig] : 7'h7F;
        x.rdy   = !m_pend;
        x.ft    = rst_n && (m_edges > 0) && ((m_edges % FRAME) == 0);
        x.edge_no = m_edges;
        exp_q.push_back(x);
    endtask

    // One clock: drive inputs, let the edge happen, record the expectation.
    task automatic cyc(input logic rst_n, input logic v, input logic [7:0] d);
        reset      = rst_n;
        data_valid = v;
        data_in    = d;
        @(posedge clk);
        model_edge(rst_n, v, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00);
    endtask

    // Hold a byte valid until the model says it was accepted (bounded).
    task automatic send(input logic [7:0] d);
        logic was_pend;
        int   tries;
        tries = 0;
        do begin
            was_pend = m_pend;
            cyc(1'b1, 1'b1, d);
            tries++;
        end while (was_pend && tries < 4 * FRAME);
        if (was_pend) begin
            checks++;
            fails++;
            $display("FAIL send_timeout byte=%02h not accepted within %0d cycles", d, tries);
        end
    endtask

    task automatic check(input string name, input int edge_no, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s edge=%0d actual=%02h expected=%02h", name, edge_no, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare it.
    always @(negedge clk) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("counter",    x.edge_no, {4'h0, counter},    {4'h0, x.cnt});
            check("digit",      x.edge_no, {4'h0, digit},      {4'h0, x.dig});
            check("seg",        x.edge_no, {1'b0, seg},        {1'b0, x.sg});
            check("data_ready", x.edge_no, {7'h00, data_ready}, {7'h00, x.rdy});
            check("frame_tick", x.edge_no, {7'h00, frame_tick}, {7'h00, x.ft});
        end
    end

    initial begin
        int guard;

        // Reset held for three clocks.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00);

        // Free-running scan, then load 0xA5 ten cycles in.
        idle(10);
        send(8'hA5);
        idle(2 * FRAME);

        // Back-to-back: 0xA5 then 0x3C held valid while stalled.
        send(8'hA5);
        send(8'h3C);
        idle(2 * FRAME);

        // Present 0x77 exactly on a wrap edge with the buffer empty.
        guard = 0;
        while (!(((m_edges + 1) % FRAME) == 0 && !m_pend) && guard < 4 * FRAME) begin
            idle(1);
            guard++;
        end
        cyc(1'b1, 1'b1, 8'h77);
        idle(2 * FRAME + 4);

        // Reset with a byte pending and counter at 9.
        send(8'h5A);
        guard = 0;
        while (((m_edges / PRESCALE) % 16) != 9 && guard < 2 * FRAME) begin
            idle(1);
            guard++;
        end
        cyc(1'b0, 1'b0, 8'h00);
        idle(2 * FRAME + 4);

        // Random traffic, including data_valid while not ready.
        for (int i = 0; i < 12 * FRAME; i++) begin
            cyc(1'b1, ($urandom_range(0, 3) == 0), 8'($urandom));
        end

        // Drain the scoreboard (bounded).
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Sequential front end for the 4-digit multiplexed seven-segment display.
- Generates the 4-bit scan counter that the anode-select logic decodes.
- Drives active-low segment patterns aligned to that counter.
- Accepts display bytes from the UART receiver through a valid/ready handshake and commits them only at frame boundaries, so the display never tears.

Parameters:
- PRESCALE, 50000, clk cycles per scan-counter step; legal range >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- data_in  input  8  byte to display; two hex digits.
- data_valid  input  1  data_in is valid this cycle.
- data_ready  output  1  byte accepted on a cycle where data_valid and data_ready are both 1.
- counter  output  4  scan counter to the anode selector. counter[3:2] = digit index, counter[1:0] = phase.
- digit  output  4  hex value of the digit currently addressed.
- seg  output  7  active-low segments {g,f,e,d,c,b,a}.
- frame_tick  output  1  one-cycle pulse on counter wrap 15->0.

Behaviour:
- Reset: one clk is the only clock. reset is synchronous and active-low, sampled on the rising edge of clk. Cleared state:
  - prescaler = 0, counter = 0.
  - shadow digits {d3,d2,d1,d0} = 16'h0000.
  - pend_valid = 0.
  - Resulting outputs: frame_tick = 0, data_ready = 1, digit = 0, seg = 7'h7F.
  - Reset mid-frame or with a byte pending discards everything.
- Prescaler:
  - Counts 0..PRESCALE-1 and generates tick when it equals PRESCALE-1, then returns to 0.
  - PRESCALE = 1 gives a tick every cycle.
- Scan counter:
  - Increments on tick; 4-bit wrap 15->0.
  - frame_tick = 1 for exactly the cycle after that wrap edge, i.e. while counter = 0 following the wrap.
- Digit mapping (index 0 = leftmost display = d3):
  - counter[3:2]=0 -> d3, 1 -> d2, 2 -> d1, 3 -> d0.
  - digit is combinational from counter and shadow, with zero latency relative to counter.
- Segments:
  - Active window is counter[1:0] == 2'b01, i.e. counter values 0001, 0101, 1001, 1101. This matches the anode decode.
  - In the active window, seg = hex_to_seg(digit). Otherwise seg = 7'h7F (blank guard phases prevent ghosting).
- Handshake and buffering:
  - data_ready = !pend_valid.
  - On accept: pend_byte <= data_in, pend_valid <= 1.
  - Commit on the edge where tick occurs with counter = 15 and pend_valid = 1:
    - shadow <= {shadow[7:0], pend_byte}, i.e. d3<=d1, d2<=d0, d1<=byte[7:4], d0<=byte[3:0].
    - pend_valid <= 0.
- Boundary cases:
  - data_valid while ready = 0: ignored. The sender must hold the byte; nothing is overwritten.
  - Accept on the same edge as a wrap with pend_valid = 0: the byte pends and commits at the next wrap, not this one.
  - Commit cycle: ready rises the cycle after commit. At most one byte per frame.
  - data_in is ignored unless accepted.
- Hex patterns {g..a}, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

Decomposition:
- Shared package (seg_pkg):
  - SEG_BLANK = 7'h7F.
  - ACTIVE_PHASE = 2'b01.
  - 16-entry hex pattern constants.
- One natural sub-module: hex_to_seg, combinational, 4-bit in, 7-bit active-low out.
- Prescaler, scan counter, pending buffer and shadow register stay in seg_scan_driver.

Test Plan (PRESCALE=4, frame = 64 cycles):
- Reset: hold reset=0 for 3 clks -> counter=0, seg=7F, data_ready=1, frame_tick=0.
- Scan timing: 64 clks from reset:
  - counter steps every 4 clks and visits 0..15.
  - At 0001 digit=0, seg=40; at 0000/0010/0011, seg=7F.
  - Exactly one frame_tick, the cycle after the 15->0 wrap.
- Load 0xA5 at cycle 10:
  - data_ready=0 from cycle 11 and display unchanged until wrap.
  - After wrap: shadow=00A5, data_ready=1 one cycle later.
  - At counter 1001: digit=A, seg=08. At 1101: digit=5, seg=12.
- Back-to-back: present 0xA5 then hold 0x3C valid:
  - 0x3C stalls while ready=0 and is accepted after the first commit.
  - After the second wrap, shadow=A53C; counter 0001 shows A (08), 0101 shows 5 (12).
- Simultaneous: data_valid with 0x77 on the wrap edge with pend empty -> not committed this frame; committed at the following wrap.
- Reset mid-operation: byte pending and counter=9, assert reset=0 for 1 clk -> shadow=0000, pend_valid=0, data_ready=1, counter=0; no commit at the next wrap.
